mont_mul_core: RTL
==================

MONT_MUL_CORE -- requirements
Module: mont_mul_core

Interface
REQ-001 The block SHALL have parameter NBITS, default 4096, meaning operand/modulus width; NBITS is a multiple of PBITS.
REQ-002 The block SHALL have parameter PBITS, default 2, meaning radix exponent (digit width); supported values are 1 and 2.
REQ-003 The block SHALL have parameter MLSIZE, default 1<<PBITS, meaning table entry count.
REQ-004 The block SHALL have port clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, width 1, reset that is asynchronous and active-high.
REQ-006 The block SHALL have port start, input, width 1, a one-cycle request pulse that captures a_in, b_in and m_in.
REQ-007 The block SHALL have ports a_in, b_in and m_in, input, width NBITS each: multiplicand, multiplier and odd modulus, with a_in, b_in < m_in.
REQ-008 The block SHALL have port busy, output, width 1, high from the accepted start until done.
REQ-009 The block SHALL have port done, output, width 1, a one-cycle pulse meaning result is valid.
REQ-010 The block SHALL have port result, output, width NBITS, holding a*b*2^-NBITS mod m.
REQ-011 The block SHALL have port tbl_start, output, width 1, a one-cycle pulse to the multiple-table generator enable.
REQ-012 The block SHALL have ports tbl_m and tbl_b, output, width NBITS each, carrying the captured m and b to the table generator.
REQ-013 The block SHALL have port tbl_done, input, width 1, the generator's tables-ready pulse.
REQ-014 The block SHALL have port mxn_tbl, input, width MLSIZE*(NBITS+PBITS), flattened k*m entries with entry k in bits [k*(NBITS+PBITS) +: NBITS+PBITS], permuted so that entry k ≡ -k mod 2^PBITS.
REQ-015 The block SHALL have port bxn_tbl, input, width (MLSIZE-1)*(NBITS+PBITS), flattened entries k=1..MLSIZE-1 with entry k = k*b in slot k-1; digit 0 adds zero internally.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, PRECOMP, ITER, FINAL and DONE.
REQ-017 In IDLE, on start=1 the block SHALL register a, b and m, clear accumulator S and digit counter, and go to PRECOMP; busy rises the next cycle.
REQ-018 On the first PRECOMP cycle the block SHALL assert tbl_start for exactly one cycle, with tbl_m/tbl_b already stable, and hold tbl_m/tbl_b until done.
REQ-019 The block SHALL stay in PRECOMP until tbl_done=1 is sampled, then go to ITER; it SHALL ignore tbl_done in any other state.
REQ-020 Each ITER cycle SHALL take the digit d = a_reg[PBITS-1:0] and form T = S + bxn[d].
REQ-021 Each ITER cycle SHALL then form S_next = (T + mxn[T[PBITS-1:0]]) >> PBITS, shift a_reg right by PBITS and increment the counter.
REQ-022 S SHALL be NBITS+2 bits wide and T NBITS+PBITS+2 bits wide, with no truncation of intermediate sums.
REQ-023 ITER SHALL last exactly NBITS/PBITS cycles, after which the FSM goes to FINAL.
REQ-024 The FINAL state SHALL last one cycle: result <= (S >= m) ? S-m : S, truncated to NBITS bits, then the FSM goes to DONE.
REQ-025 In DONE the block SHALL pulse done for one cycle, deassert busy in that same cycle, and return to IDLE.
REQ-026 Latency from tbl_done sampled to done high SHALL be exactly NBITS/PBITS+2 cycles.
REQ-027 result SHALL hold its value until the next FINAL; it SHALL NOT change in any other state.
REQ-028 A start received while busy=1 SHALL be ignored without disturbing the operation.
REQ-029 A start coincident with the done cycle SHALL be ignored; a new start is accepted only in IDLE.
REQ-030 a_in=0 or b_in=0 SHALL produce result 0 through the full-latency path with no shortcut.

Reset
REQ-031 On rst=1, asynchronously, the FSM SHALL go to IDLE and busy, done, tbl_start, result, tbl_m, tbl_b, S, a_reg and the counter SHALL clear to 0.
REQ-032 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst falls SHALL be processed normally.

Verification
REQ-033 With NBITS=8, PBITS=2, m=13, a=5, b=7 and tbl_done 3 cycles after tbl_start, the bench SHALL see result=1 and done exactly 6 cycles after tbl_done.
REQ-034 With m=13, a=12, b=12, the bench SHALL see result=3; with a=1, b=9 (R mod m), it SHALL see result=1.
REQ-035 With a=0, b=7, m=13, the bench SHALL see result=0 with the same latency as REQ-033.
REQ-036 A start pulse during ITER SHALL leave result, done timing and tbl_start count (one) unchanged.
REQ-037 Asserting rst during ITER, then starting m=13, a=5, b=7, SHALL give outputs 0 immediately, no done for the aborted operation, and result=1 for the next operation.
REQ-038 With PBITS=1, NBITS=8, m=13, a=5, b=7, the bench SHALL see result=1 and done 10 cycles after tbl_done.

Source files
------------

// File: rtl/mont_mul_core.sv
// -----------------------------------------------------------------------------
// mont_mul_core
//   Radix-2^PBITS Montgomery multiplier: result = a * b * 2^-NBITS mod m.
//   Multiples of m and b come from an external table generator, which is kicked
//   once per operation through tbl_start / tbl_m / tbl_b and answers with
//   tbl_done once mxn_tbl / bxn_tbl are valid.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start               one-cycle request pulse, accepted only in IDLE
//   a_in, b_in, m_in    multiplicand, multiplier, odd modulus (a, b < m)
//   busy                high from the cycle after an accepted start until done
//   done                one-cycle pulse, result valid
//   result              Montgomery product, held until the next FINAL
//   tbl_start           one-cycle enable to the table generator
//   tbl_m, tbl_b        captured m and b, stable for the whole operation
//   tbl_done            generator tables-ready pulse (only honoured in PRECOMP)
//   mxn_tbl             entry k = q*m with q*m == -k mod 2^PBITS
//   bxn_tbl             entry k (slot k-1) = k*b for k = 1..MLSIZE-1
//
// Handshake: start is a request with no ready; it is taken only when the FSM is
// in IDLE and silently dropped in every other state, so callers wait for done
// (or busy low outside the done cycle) before issuing the next request.
// -----------------------------------------------------------------------------
module mont_mul_core #(
  parameter int NBITS  = 4096,
  parameter int PBITS  = 2,
  parameter int MLSIZE = 1 << PBITS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [NBITS-1:0]                 a_in,
  input  logic [NBITS-1:0]                 b_in,
  input  logic [NBITS-1:0]                 m_in,
  output logic                             busy,
  output logic                             done,
  output logic [NBITS-1:0]                 result,
  output logic                             tbl_start,
  output logic [NBITS-1:0]                 tbl_m,
  output logic [NBITS-1:0]                 tbl_b,
  input  logic                             tbl_done,
  input  logic [MLSIZE*(NBITS+PBITS)-1:0]  mxn_tbl,
  input  logic [(MLSIZE-1)*(NBITS+PBITS)-1:0] bxn_tbl
);

  localparam int EW     = NBITS + PBITS;      // table entry width
  localparam int SW     = NBITS + 2;          // accumulator width
  localparam int TW     = NBITS + PBITS + 2;  // intermediate sum width
  localparam int DIGITS = NBITS / PBITS;
  localparam int CW     = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRECOMP = 3'd1,
    ITER    = 3'd2,
    FINAL   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [NBITS-1:0]  a_reg, b_reg, m_reg;
  logic [SW-1:0]     s_reg;
  logic [CW-1:0]     cnt;
  logic              tbl_start_q;

  logic [PBITS-1:0]  dig;
  logic [EW-1:0]     bx, mx;
  logic [TW-1:0]     t_sum, u_sum;
  logic [SW-1:0]     s_next;
  logic              s_ge_m;
  logic [SW-1:0]     s_minus_m;

  assign tbl_start = tbl_start_q;
  assign tbl_m     = m_reg;
  assign tbl_b     = b_reg;

  // One Montgomery digit step. Digit 0 of b contributes nothing, so the b table
  // only carries entries 1..MLSIZE-1. The m multiple is picked by the low digit
  // of T so that the sum is divisible by 2^PBITS and the shift is exact.
  // S stays below 2m, so T + q*m stays below 2^(NBITS+3), which TW covers.
  always_comb begin
    dig = a_reg[PBITS-1:0];
    bx  = '0;
    for (int k = 1; k < MLSIZE; k++) begin
      if (dig == PBITS'(k)) bx = bxn_tbl[(k-1)*EW +: EW];
    end
    t_sum = TW'(s_reg) + TW'(bx);
    mx    = '0;
    for (int k = 0; k < MLSIZE; k++) begin
      if (t_sum[PBITS-1:0] == PBITS'(k)) mx = mxn_tbl[k*EW +: EW];
    end
    u_sum     = t_sum + TW'(mx);
    s_next    = SW'(u_sum >> PBITS);
    s_ge_m    = (s_reg >= {2'b00, m_reg});
    s_minus_m = s_reg - {2'b00, m_reg};
  end

  // Next state and status outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = PRECOMP;
      end
      PRECOMP: begin
        busy = 1'b1;
        if (tbl_done) state_nx = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (cnt == CW'(DIGITS - 1)) state_nx = FINAL;
      end
      FINAL: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      m_reg       <= '0;
      s_reg       <= '0;
      cnt         <= '0;
      tbl_start_q <= 1'b0;
      result      <= '0;
    end else begin
      // Pulses during the first PRECOMP cycle, when tbl_m/tbl_b are already valid
      tbl_start_q <= (state == IDLE) && start;
      if (state == IDLE && start) begin
        a_reg <= a_in;
        b_reg <= b_in;
        m_reg <= m_in;
        s_reg <= '0;
        cnt   <= '0;
      end
      if (state == ITER) begin
        s_reg <= s_next;
        a_reg <= a_reg >> PBITS;
        cnt   <= cnt + CW'(1);
      end
      if (state == FINAL) begin
        result <= s_ge_m ? NBITS'(s_minus_m) : NBITS'(s_reg);
      end
    end
  end

endmodule
